mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single-port unified instruction/data RAM between the instruction-fetch requester (IF) and the load/store requester (LS) of the multicycle CPU. It holds each requester's command through a fixed-latency memory access, returns read data, and pulses a one-cycle acknowledge. Round-robin arbitration lets neither requester starve the other. It sits between the control-unit-driven fetch and LD/ST paths and the RAM macro.

## Interface
Parameters:
- ADDR_W, 10, word address width
- DATA_W, 32, data width
- RD_LAT, 2, RAM read latency in cycles, from the clock edge that samples mem_en to valid mem_rdata; legal values are RD_LAT >= 1

Ports (reset rst, asynchronous, active-high; clock clk):
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- if_req  in  1  fetch request; hold high until if_ack
- if_addr  in  ADDR_W  fetch address; stable while if_req is high
- if_rdata  out  DATA_W  fetched word, registered, held until the next IF ack
- if_ack  out  1  one-cycle completion pulse
- ls_req  in  1  load/store request; hold high until ls_ack
- ls_we  in  1  1 = store, 0 = load; stable with ls_req
- ls_addr  in  ADDR_W  data address
- ls_wdata  in  DATA_W  store data
- ls_rdata  out  DATA_W  load data, registered, held until the next LS load ack
- ls_ack  out  1  one-cycle completion pulse
- mem_en  out  1  RAM access strobe
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data
- busy  out  1  high whenever the state is not IDLE
- gnt_id  out  1  owner of the current or last access: 0 = IF, 1 = LS

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT, RESP. All outputs are registered.
- **IDLE:** requests are sampled only in this state.
  - If exactly one request is high, that requester is granted.
  - If both are high, the requester not equal to `last_gnt` is granted.
  - On grant, the block latches the address, we and wdata into the mem_* registers, sets mem_en=1, updates gnt_id and last_gnt, and moves to ISSUE.
  - IF accesses are always reads (mem_we=0).
- **ISSUE:** lasts one cycle with mem_en high.
  - Next, mem_en returns to 0.
  - A write goes to RESP.
  - A read goes to WAIT with the counter loaded to RD_LAT-1.
- **WAIT:** the counter decrements each cycle.
  - When the counter is 0, mem_rdata is captured into the granted requester's rdata register and the state moves to RESP.
  - Capture happens RD_LAT edges after the sampling edge of mem_en.
- **RESP:** the granted requester's ack is high for exactly this one cycle, then the state returns to IDLE.
  - Requests are not sampled in RESP.
  - A requester must drop req on the edge that ends its ack cycle. A req still high in the following IDLE cycle is treated as a new request.
- mem_addr and mem_wdata hold their last values outside ISSUE. mem_we is cleared when leaving ISSUE.
- A store never updates ls_rdata.
- Reset values:
  - State is IDLE; last_gnt = 0 (IF), so the first tie goes to LS.
  - All outputs are 0: rdata registers, acks, mem_*, busy, gnt_id.
- Reset mid-operation: the asynchronous reset forces IDLE immediately.
  - mem_en and mem_we drop in the same cycle.
  - No ack is issued for the abandoned access.
  - A write abandoned in ISSUE may or may not have reached the RAM; the core's reset discards it.
- RD_LAT is a synthesis-time check: RD_LAT < 1 is a fatal elaboration error.

## Timing
Edge k is the IDLE edge that grants a request.
- **Store:** mem_en=mem_we=1 in cycle k..k+1; ls_ack is high in cycle k+1..k+2; IDLE is reached at k+2.
- **Read:** mem_en=1 in cycle k..k+1; rdata is captured at edge k+1+RD_LAT; ack is high in the following cycle; IDLE is reached at k+2+RD_LAT.
- Minimum grant-to-grant spacing:
  - 3 cycles for a write.
  - RD_LAT+3 cycles for a read (5 at default).
- Worst-case wait for a requester when the other requester also asks: one full competing access plus its own access (no starvation).
- The counter width is clog2(RD_LAT) bits; a single bit is used when RD_LAT=1.

## Structure
- Package mem_arb_pkg:
  - state enum (IDLE, ISSUE, WAIT, RESP)
  - requester IDs REQ_IF=1'b0, REQ_LS=1'b1
- Sub-module arb_rr2: a two-input round-robin pick.
  - Combinational inputs: req[1:0] and last_gnt.
  - Outputs: gnt_valid and gnt_id.
  - The last_gnt register lives in the parent and is updated only on an IDLE grant.

## Test plan
- **Reset then single load:** after reset, ls_req=1, ls_we=0, ls_addr=0x05, RAM[5]=0xDEADBEEF, RD_LAT=2 → mem_en high for one cycle with mem_addr=0x05; ls_ack pulses 3 cycles after the grant edge; ls_rdata=0xDEADBEEF; busy=0 again the next cycle.
- **Store:** ls_we=1, ls_addr=0x10, ls_wdata=0x12345678 → mem_we=1 for exactly one cycle; ls_ack the next cycle; a subsequent IF read of 0x10 returns 0x12345678 and ls_rdata is unchanged.
- **Tie and round robin:** if_req and ls_req both held high from reset → grant order LS, IF, LS, IF (gnt_id 1,0,1,0); each ack lasts one cycle; IF read addr 0x00 gives 0x00000013 per the preloaded image.
- **Req held after ack:** the IF requester keeps if_req high for 1 cycle beyond if_ack → a second IF access is issued; a requester dropping req correctly → no duplicate access.
- **Reset mid-read:** rst asserted in WAIT → mem_en, acks, busy and rdata go to 0 immediately; no ack after reset release; the next ls_req completes normally with last_gnt=IF behaviour.
- **RD_LAT=1 build:** a load completes with ack 2 cycles after the grant edge, and data is correct.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the unified-RAM port arbiter.
//   state_t  - access sequencer states
//   REQ_IF / REQ_LS - requester identifiers used for grant ownership
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_LS = 1'b1;

endpackage

// File: rtl/arb_rr2.sv
// arb_rr2: two-input round-robin pick (purely combinational).
//   req[1:0]  in  - request vector, bit 0 = IF, bit 1 = LS
//   last_gnt  in  - owner of the previous grant (register kept by the parent)
//   gnt_valid out - at least one request present
//   gnt_id    out - chosen requester; on a tie the one that did not win last
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic       gnt_valid,
  output logic       gnt_id
);

  always_comb begin
    gnt_valid = |req;
    gnt_id    = REQ_IF;
    if (req == 2'b11) begin
      gnt_id = (last_gnt == REQ_IF) ? REQ_LS : REQ_IF;
    end else if (req[1]) begin
      gnt_id = REQ_LS;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares a single-port fixed-latency RAM between the
// instruction-fetch (IF) and load/store (LS) requesters of the CPU.
//   clk, rst            - clock, asynchronous active-high reset
//   if_req/if_addr      - fetch request (always a read)
//   if_rdata/if_ack     - fetched word (held) and one-cycle completion pulse
//   ls_req/ls_we/ls_addr/ls_wdata - load/store request
//   ls_rdata/ls_ack     - load data (held; stores leave it alone) and pulse
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata - RAM macro port
//   busy                - sequencer not idle
//   gnt_id              - owner of the current or last access (0 IF, 1 LS)
// Read data is captured RD_LAT edges after the edge that samples mem_en.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ls_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              gnt_id
);

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  generate
    if (RD_LAT < 1) begin : g_bad_rd_lat
      $fatal(1, "mem_port_arbiter: RD_LAT must be >= 1");
    end
  endgenerate

  state_t             state;
  logic               last_gnt;
  logic [CNT_W-1:0]   cnt;
  logic               gnt_valid;
  logic               gnt_pick;

  arb_rr2 u_arb (
    .req       ({ls_req, if_req}),
    .last_gnt  (last_gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_pick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      last_gnt  <= REQ_IF;
      cnt       <= '0;
      if_rdata  <= '0;
      ls_rdata  <= '0;
      if_ack    <= 1'b0;
      ls_ack    <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      gnt_id    <= REQ_IF;
    end else begin
      // Acks are asserted only on the transition into RESP.
      if_ack <= 1'b0;
      ls_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            state    <= ISSUE;
            busy     <= 1'b1;
            mem_en   <= 1'b1;
            gnt_id   <= gnt_pick;
            last_gnt <= gnt_pick;
            if (gnt_pick == REQ_LS) begin
              mem_addr  <= ls_addr;
              mem_we    <= ls_we;
              mem_wdata <= ls_wdata;
            end else begin
              mem_addr <= if_addr;
              mem_we   <= 1'b0;
            end
          end
        end
        ISSUE: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          if (mem_we) begin
            // Only LS can write, so a write always completes to LS.
            state  <= RESP;
            ls_ack <= 1'b1;
          end else begin
            state <= WAIT;
            cnt   <= CNT_W'(RD_LAT - 1);
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state <= RESP;
            if (gnt_id == REQ_LS) begin
              ls_rdata <= mem_rdata;
              ls_ack   <= 1'b1;
            end else begin
              if_rdata <= mem_rdata;
              if_ack   <= 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed requests push expected
// grants/responses; a negedge monitor checks grants, ack owner, latency and data.
module tb_mem_port_arbiter;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, ls_req, ls_we;
  logic [9:0]  if_addr, ls_addr;
  logic [31:0] ls_wdata;
  logic [31:0] if_rdata, ls_rdata;
  logic        if_ack, ls_ack;
  logic        mem_en, mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        busy, gnt_id;

  // second instance built with RD_LAT=1
  logic        r1_ls_req, r1_ls_we;
  logic [9:0]  r1_ls_addr;
  logic [31:0] r1_if_rdata, r1_ls_rdata, r1_mem_wdata, r1_mem_rdata;
  logic        r1_if_ack, r1_ls_ack, r1_mem_en, r1_mem_we, r1_busy, r1_gnt_id;
  logic [9:0]  r1_mem_addr;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(10), .DATA_W(32), .RD_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_rdata(ls_rdata), .ls_ack(ls_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .gnt_id(gnt_id)
  );

  mem_port_arbiter #(.ADDR_W(10), .DATA_W(32), .RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst),
    .if_req(1'b0), .if_addr(10'd0), .if_rdata(r1_if_rdata), .if_ack(r1_if_ack),
    .ls_req(r1_ls_req), .ls_we(r1_ls_we), .ls_addr(r1_ls_addr), .ls_wdata(32'd0),
    .ls_rdata(r1_ls_rdata), .ls_ack(r1_ls_ack),
    .mem_en(r1_mem_en), .mem_we(r1_mem_we), .mem_addr(r1_mem_addr),
    .mem_wdata(r1_mem_wdata), .mem_rdata(r1_mem_rdata), .busy(r1_busy), .gnt_id(r1_gnt_id)
  );

  // RAM models
  logic [31:0] ram [0:1023];
  logic [31:0] p1, p2;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      p1 <= ram[mem_addr];
    end
    p2 <= p1;
  end
  assign mem_rdata = p2;

  always @(posedge clk) begin
    if (r1_mem_en) r1_mem_rdata <= ram[r1_mem_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  typedef struct {
    bit          id;
    bit          we;
    logic [9:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];

  function automatic void push(bit id, bit we, logic [9:0] addr, logic [31:0] data);
    exp_t e;
    e.id = id; e.we = we; e.addr = addr; e.data = data;
    q.push_back(e);
  endfunction

  // Monitor
  int          cyc = 0, gcyc = 0, ackcyc = 0;
  bit          pend = 0, post = 0;
  exp_t        cur;
  logic [31:0] ls_model = '0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      pend = 0; post = 0; ls_model = '0;
    end else begin
      if (post && cyc == ackcyc + 1) begin
        post = 0;
        chk(!busy && !if_ack && !ls_ack, "post_ack_idle", {29'd0, busy, if_ack, ls_ack}, 32'd0);
      end
      if (mem_we && !mem_en) chk(0, "mem_we_stray", {31'd0, mem_we}, 32'd0);
      if (pend && mem_en) begin
        chk(0, "mem_en_width", {31'd0, mem_en}, 32'd0);
      end else if (mem_en) begin
        if (q.size() == 0) begin
          chk(0, "spurious_grant", {22'd0, mem_addr}, 32'd0);
        end else begin
          cur = q[0];
          pend = 1; gcyc = cyc;
          chk(gnt_id == cur.id, "grant_id", {31'd0, gnt_id}, {31'd0, cur.id});
          chk(mem_addr == cur.addr, "grant_addr", {22'd0, mem_addr}, {22'd0, cur.addr});
          chk(mem_we == cur.we, "grant_we", {31'd0, mem_we}, {31'd0, cur.we});
          if (cur.we) chk(mem_wdata == cur.data, "grant_wdata", mem_wdata, cur.data);
        end
      end
      if (if_ack || ls_ack) begin
        if (!pend) begin
          chk(0, "spurious_ack", {30'd0, if_ack, ls_ack}, 32'd0);
        end else begin
          chk(cur.id ? (ls_ack && !if_ack) : (if_ack && !ls_ack), "ack_owner",
              {30'd0, if_ack, ls_ack}, cur.id ? 32'd1 : 32'd2);
          chk(cyc - gcyc == (cur.we ? 1 : LAT + 1), "ack_latency", cyc - gcyc,
              cur.we ? 32'd1 : LAT + 1);
          if (!cur.we) begin
            if (cur.id) begin
              chk(ls_rdata == cur.data, "ls_rdata", ls_rdata, cur.data);
              ls_model = cur.data;
            end else begin
              chk(if_rdata == cur.data, "if_rdata", if_rdata, cur.data);
            end
          end else begin
            chk(ls_rdata == ls_model, "ls_rdata_after_store", ls_rdata, ls_model);
          end
          chk(!mem_en && !mem_we, "mem_quiet_at_ack", {30'd0, mem_en, mem_we}, 32'd0);
          void'(q.pop_front());
          pend = 0; post = 1; ackcyc = cyc;
        end
      end
      if (pend && cyc - gcyc > LAT + 4) begin
        chk(0, "ack_timeout", cyc - gcyc, LAT + 1);
        pend = 0;
        if (q.size() != 0) void'(q.pop_front());
      end
    end
  end

  task automatic if_access(input logic [9:0] a, input int hold);
    bit ok = 0;
    if_addr = a; if_req = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (if_ack) begin ok = 1; break; end
    end
    if (!ok) chk(0, "if_wait_timeout", 32'd0, 32'd1);
    repeat (1 + hold) @(posedge clk);
    #1 if_req = 1'b0;
  endtask

  task automatic ls_access(input bit we, input logic [9:0] a, input logic [31:0] d);
    bit ok = 0;
    ls_we = we; ls_addr = a; ls_wdata = d; ls_req = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (ls_ack) begin ok = 1; break; end
    end
    if (!ok) chk(0, "ls_wait_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 ls_req = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && (q.size() != 0 || pend); i++) @(negedge clk);
    if (q.size() != 0 || pend) chk(0, "drain_timeout", q.size(), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int  n;
    bit  found;
    for (int i = 0; i < 1024; i++) ram[i] = '0;
    ram[0] = 32'h00000013;
    ram[1] = 32'h00100093;
    ram[5] = 32'hDEADBEEF;
    ram[6] = 32'h0BADF00D;
    ram[7] = 32'hCAFEF00D;
    p1 = '0; p2 = '0; r1_mem_rdata = '0;

    rst = 1'b1;
    if_req = 0; ls_req = 0; ls_we = 0; if_addr = '0; ls_addr = '0; ls_wdata = '0;
    r1_ls_req = 0; r1_ls_we = 0; r1_ls_addr = '0;
    repeat (2) @(negedge clk);
    chk(if_rdata == 0 && ls_rdata == 0, "reset_rdata", if_rdata | ls_rdata, 32'd0);
    chk({if_ack, ls_ack, mem_en, mem_we, busy, gnt_id} == 6'd0, "reset_ctrl",
        {26'd0, if_ack, ls_ack, mem_en, mem_we, busy, gnt_id}, 32'd0);
    chk(mem_addr == 0 && mem_wdata == 0, "reset_mem_bus", {22'd0, mem_addr} | mem_wdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // RD_LAT=1 instance: load of address 7
    r1_ls_addr = 10'd7; r1_ls_req = 1'b1;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (r1_mem_en) begin found = 1; break; end
    end
    chk(found, "r1_grant", {31'd0, found}, 32'd1);
    n = 0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (r1_ls_ack) begin n = i; break; end
    end
    chk(n == 2, "r1_ack_latency", n, 32'd2);
    chk(r1_ls_rdata == 32'hCAFEF00D, "r1_ls_rdata", r1_ls_rdata, 32'hCAFEF00D);
    @(posedge clk); #1;
    r1_ls_req = 1'b0;
    chk(!r1_ls_ack && !r1_busy, "r1_ack_width", {30'd0, r1_ls_ack, r1_busy}, 32'd0);
    @(negedge clk);

    // single load after reset
    push(1, 0, 10'h05, 32'hDEADBEEF);
    ls_access(0, 10'h05, 32'h0);
    drain();

    // store, then fetch of the stored word
    push(1, 1, 10'h10, 32'h12345678);
    ls_access(1, 10'h10, 32'h12345678);
    drain();
    push(0, 0, 10'h10, 32'h12345678);
    if_access(10'h10, 0);
    drain();
    chk(ls_rdata == 32'hDEADBEEF, "ls_rdata_kept", ls_rdata, 32'hDEADBEEF);

    // req held one cycle past ack -> second access; proper drop -> one access
    push(0, 0, 10'h00, 32'h00000013);
    push(0, 0, 10'h00, 32'h00000013);
    if_access(10'h00, 1);
    drain();
    push(0, 0, 10'h01, 32'h00100093);
    if_access(10'h01, 0);
    drain();
    repeat (6) @(negedge clk);

    // tie from reset: LS, IF, LS, IF
    rst = 1'b1;
    q.delete();
    push(1, 0, 10'h05, 32'hDEADBEEF);
    push(0, 0, 10'h00, 32'h00000013);
    push(1, 0, 10'h06, 32'h0BADF00D);
    push(0, 0, 10'h01, 32'h00100093);
    if_addr = 10'h00; if_req = 1'b1;
    ls_addr = 10'h05; ls_we = 1'b0; ls_req = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    fork
      begin
        ls_access(0, 10'h05, 32'h0);
        ls_access(0, 10'h06, 32'h0);
      end
      begin
        if_access(10'h00, 0);
        if_access(10'h01, 0);
      end
    join
    drain();

    // reset during WAIT
    push(1, 0, 10'h06, 32'h0BADF00D);
    ls_we = 1'b0; ls_addr = 10'h06; ls_req = 1'b1;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (mem_en) begin found = 1; break; end
    end
    chk(found, "midrd_grant", {31'd0, found}, 32'd1);
    @(posedge clk); #3;
    rst = 1'b1;
    q.delete();
    #1;
    chk({mem_en, mem_we, if_ack, ls_ack, busy} == 5'd0, "midrd_ctrl",
        {27'd0, mem_en, mem_we, if_ack, ls_ack, busy}, 32'd0);
    chk(ls_rdata == 0 && if_rdata == 0, "midrd_rdata", ls_rdata | if_rdata, 32'd0);
    ls_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk(q.size() == 0 && !busy, "midrd_quiet", {31'd0, busy}, 32'd0);
    push(1, 0, 10'h05, 32'hDEADBEEF);
    push(0, 0, 10'h01, 32'h00100093);
    fork
      ls_access(0, 10'h05, 32'h0);
      if_access(10'h01, 0);
    join
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
